// File: rtl/key_debounce_multi.sv
// key_debounce_multi
// Multi-channel push-button debouncer. A free-running sample tick (one
// Sys_CLK pulse every TICK_DIV cycles) drives a per-key shift-register filter
// fed by a two-flop synchroniser. A key changes debounced state only after
// FILTER_LEN consecutive equal samples. Each change produces a one-cycle
// press or release pulse.
//
// Optional build macro: KEY_DEBOUNCE_LONG_EN
//   When defined, each key also reports a long press (Key_Long pulse after
//   LONG_TICKS ticks held) and then auto-repeats Key_Press every
//   REPEAT_TICKS ticks. When undefined, Key_Long is tied low and the
//   hold counters do not exist.
//
// Ports
//   Sys_CLK      in   system clock, rising edge
//   Sys_RST      in   asynchronous reset, active high
//   Key_In       in   raw key pins [KEY_NUM]
//   Key_Out      out  debounced level, 1 = pressed
//   Key_Press    out  one-cycle pulse on press (and on auto-repeat)
//   Key_Release  out  one-cycle pulse on release
//   Key_Long     out  one-cycle pulse at long-press threshold
//
// Per-key states
//   state     | meaning
//   S_IDLE    | debounced released
//   S_PRESSED | debounced pressed, counting towards long press
//   S_LONG    | long press reported, counting towards first repeat
//   S_REPEAT  | auto-repeating Key_Press every REPEAT_TICKS ticks
module key_debounce_multi #(
  parameter int KEY_NUM      = 2,
  parameter int TICK_DIV     = 50000,
  parameter int FILTER_LEN   = 12,
  parameter int ACTIVE_LOW   = 0,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic               Sys_CLK,
  input  logic               Sys_RST,
  input  logic [KEY_NUM-1:0] Key_In,
  output logic [KEY_NUM-1:0] Key_Out,
  output logic [KEY_NUM-1:0] Key_Press,
  output logic [KEY_NUM-1:0] Key_Release,
  output logic [KEY_NUM-1:0] Key_Long
);

  localparam int TW = $clog2(TICK_DIV);
  // Raw pin value of a released key; synchronisers reset to it and the
  // XOR below maps it to sample 0.
  localparam logic [KEY_NUM-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

`ifdef KEY_DEBOUNCE_LONG_EN
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW       = $clog2(HOLD_MAX) + 1;
  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LONG, S_REPEAT} key_state_e;
`else
  typedef enum logic {S_IDLE, S_PRESSED} key_state_e;
  logic unused_hold_cfg;
  assign unused_hold_cfg = (LONG_TICKS != REPEAT_TICKS);
`endif

  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick;
  logic [KEY_NUM-1:0] sync_meta_q, sync_q, sample;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      tick_cnt_q  <= '0;
      sync_meta_q <= RAW_IDLE;
      sync_q      <= RAW_IDLE;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      sync_meta_q <= Key_In;
      sync_q      <= sync_meta_q;
    end
  end

  assign sample = sync_q ^ RAW_IDLE;

  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  all_on, all_off;
    key_state_e            state_q;
    logic                  out_q, press_q, rel_q;

    // The decision uses the value being shifted in, so Key_Out moves on
    // the edge that ends the deciding tick cycle.
    assign filt_d  = {filt_q[FILTER_LEN-2:0], sample[k]};
    assign all_on  = &filt_d;
    assign all_off = ~|filt_d;

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
      if (Sys_RST) filt_q <= '0;
      else if (tick) filt_q <= filt_d;
    end

`ifdef KEY_DEBOUNCE_LONG_EN
    logic [HW-1:0] hold_q, hold_inc;
    logic          long_q;

    assign hold_inc = hold_q + HW'(1);

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
      if (Sys_RST) begin
        state_q <= S_IDLE;
        out_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        hold_q  <= '0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        if (tick) begin
          case (state_q)
            S_IDLE: begin
              if (all_on) begin
                state_q <= S_PRESSED;
                out_q   <= 1'b1;
                press_q <= 1'b1;
                hold_q  <= '0;
              end
            end
            S_PRESSED: begin
              if (all_off) begin
                state_q <= S_IDLE;
                out_q   <= 1'b0;
                rel_q   <= 1'b1;
                hold_q  <= '0;
              end else if (hold_inc == HW'(LONG_TICKS)) begin
                state_q <= S_LONG;
                long_q  <= 1'b1;
                hold_q  <= '0;
              end else begin
                hold_q <= hold_inc;
              end
            end
            S_LONG, S_REPEAT: begin
              // Release is checked first so it suppresses a coincident repeat.
              if (all_off) begin
                state_q <= S_IDLE;
                out_q   <= 1'b0;
                rel_q   <= 1'b1;
                hold_q  <= '0;
              end else if (hold_inc == HW'(REPEAT_TICKS)) begin
                state_q <= S_REPEAT;
                press_q <= 1'b1;
                hold_q  <= '0;
              end else begin
                hold_q <= hold_inc;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end

    assign Key_Long[k] = long_q;
`else
    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
      if (Sys_RST) begin
        state_q <= S_IDLE;
        out_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        if (tick) begin
          if (state_q == S_IDLE) begin
            if (all_on) begin
              state_q <= S_PRESSED;
              out_q   <= 1'b1;
              press_q <= 1'b1;
            end
          end else if (all_off) begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
            rel_q   <= 1'b1;
          end
        end
      end
    end

    assign Key_Long[k] = 1'b0;
`endif

    assign Key_Out[k]     = out_q;
    assign Key_Press[k]   = press_q;
    assign Key_Release[k] = rel_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
module tb_key_debounce_multi;
  localparam int KN = 4;
  localparam int TD = 4;
  localparam int FL = 4;
  localparam int LT = 10;
  localparam int RT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [KN-1:0] key_in, k_out, k_press, k_rel, k_long;
  logic [0:0]    key_al, al_out, al_press, al_rel, al_long;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .KEY_NUM(KN), .TICK_DIV(TD), .FILTER_LEN(FL), .ACTIVE_LOW(0),
    .LONG_TICKS(LT), .REPEAT_TICKS(RT)
  ) dut (
    .Sys_CLK(clk), .Sys_RST(rst), .Key_In(key_in), .Key_Out(k_out),
    .Key_Press(k_press), .Key_Release(k_rel), .Key_Long(k_long)
  );

  key_debounce_multi #(
    .KEY_NUM(1), .TICK_DIV(TD), .FILTER_LEN(FL), .ACTIVE_LOW(1)
  ) dut_al (
    .Sys_CLK(clk), .Sys_RST(rst), .Key_In(key_al), .Key_Out(al_out),
    .Key_Press(al_press), .Key_Release(al_rel), .Key_Long(al_long)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;   // 0 press, 1 release, 2 long
    logic [KN-1:0] mask;
    int            cmin;
    int            cmax;
  } ev_t;
  ev_t sbq[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected event whose timing follows from a key edge driven at cycle c0.
  task automatic expect_ev(input int kind, input logic [KN-1:0] m, input int c0);
    ev_t e;
    e.kind = kind;
    e.mask = m;
    e.cmin = c0 + (FL - 1) * TD + 2;
    e.cmax = c0 + FL * TD + TD + 2;
    sbq.push_back(e);
  endtask

  task automatic expect_at(input int kind, input logic [KN-1:0] m, input int c);
    ev_t e;
    e.kind = kind;
    e.mask = m;
    e.cmin = c;
    e.cmax = c;
    sbq.push_back(e);
  endtask

  task automatic match(input int kind, input logic [KN-1:0] m);
    ev_t e;
    if (sbq.size() == 0) begin
      chk($sformatf("unexpected_kind%0d", kind), 32'(m), 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_mask", 32'(m), 32'(e.mask));
      chk("ev_not_early", 32'(cyc >= e.cmin), 32'd1);
      chk("ev_not_late", 32'(cyc <= e.cmax), 32'd1);
    end
  endtask

  logic [KN-1:0] prev_press = '0, prev_rel = '0;
  int al_press_cnt = 0, al_rel_cnt = 0, al_long_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (|k_press) begin
        match(0, k_press);
        chk("press_gap", 32'(k_press & prev_press), 32'd0);
      end
      if (|k_rel) begin
        match(1, k_rel);
        chk("rel_gap", 32'(k_rel & prev_rel), 32'd0);
      end
      if (|k_long) match(2, k_long);
      if (al_press[0]) al_press_cnt++;
      if (al_rel[0]) al_rel_cnt++;
      if (al_long[0]) al_long_cnt++;
    end
    prev_press <= k_press;
    prev_rel   <= k_rel;
  end

  task automatic wait_out(input int k, input logic lvl, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (k_out[k] === lvl) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("wait_out_timeout", 32'd0, 32'd1);
  endtask

  int c0, p;

  initial begin
    rst    = 1'b1;
    key_in = '0;
    key_al = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(k_out), 32'd0);
    chk("rst_press", 32'(k_press), 32'd0);
    chk("rst_rel", 32'(k_rel), 32'd0);
    chk("rst_long", 32'(k_long), 32'd0);
    chk("rst_al_out", 32'(al_out), 32'd0);

    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_out", 32'(k_out), 32'd0);
    chk("idle_al_out", 32'(al_out), 32'd0);

    // All keys pressed on one cycle
    key_in = 4'hF;
    expect_ev(0, 4'hF, cyc);
    wait_out(0, 1'b1, p);
    @(negedge clk);
    chk("simul_out", 32'(k_out), 32'hF);

    // Asynchronous reset mid-press, keys kept held
    #2 rst = 1'b1;
    #1;
    chk("arst_out", 32'(k_out), 32'd0);
    chk("arst_press", 32'(k_press), 32'd0);
    chk("arst_rel", 32'(k_rel), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_ev(0, 4'hF, cyc);
    wait_out(0, 1'b1, p);
    @(negedge clk);
    chk("post_rst_out", 32'(k_out), 32'hF);

    key_in = 4'h0;
    expect_ev(1, 4'hF, cyc);
    wait_out(0, 1'b0, p);
    @(negedge clk);
    chk("all_rel_out", 32'(k_out), 32'h0);

    // Key1 held, key0 bounces then settles pressed
    key_in[1] = 1'b1;
    expect_ev(0, 4'h2, cyc);
    wait_out(1, 1'b1, p);
    for (int i = 0; i < 14; i++) begin
      key_in[0] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    key_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("bounce_no_press", 32'(k_out), 32'h2);
    key_in[0] = 1'b1;
    expect_ev(0, 4'h1, cyc);
    wait_out(0, 1'b1, p);
    repeat (10) @(negedge clk);
    chk("bounce_out", 32'(k_out), 32'h3);

    // One-tick glitch, then a FILTER_LEN-1 tick dip: neither releases
    key_in[0] = 1'b0;
    repeat (TD) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_out", 32'(k_out), 32'h3);
    key_in[0] = 1'b0;
    repeat ((FL - 1) * TD) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("short_dip_out", 32'(k_out), 32'h3);

    // FILTER_LEN tick dip: releases, then re-presses
    key_in[0] = 1'b0;
    expect_ev(1, 4'h1, cyc);
    repeat (FL * TD) @(negedge clk);
    key_in[0] = 1'b1;
    expect_ev(0, 4'h1, cyc);
    repeat (40) @(negedge clk);
    chk("full_dip_out", 32'(k_out), 32'h3);

    key_in = 4'h0;
    expect_ev(1, 4'h3, cyc);
    wait_out(0, 1'b0, p);
    repeat (5) @(negedge clk);
    chk("rel_both_out", 32'(k_out), 32'h0);

    // Long hold of key0: release driven right after hold tick 28
    key_in[0] = 1'b1;
    expect_ev(0, 4'h1, cyc);
    wait_out(0, 1'b1, p);
`ifdef KEY_DEBOUNCE_LONG_EN
    expect_at(2, 4'h1, p + LT * TD);
    for (int j = 0; j < 7; j++) expect_at(0, 4'h1, p + (LT + RT + RT * j) * TD);
`endif
    expect_at(1, 4'h1, p + 32 * TD);
    while (cyc < p + 28 * TD) @(negedge clk);
    chk("long_hold_out", 32'(k_out), 32'h1);
    key_in[0] = 1'b0;
    wait_out(0, 1'b0, p);
    repeat (60) @(negedge clk);
    chk("long_after_out", 32'(k_out), 32'h0);

    // Active-low channel
    key_al = 1'b0;
    repeat (FL * TD + TD + 8) @(negedge clk);
    chk("al_press_out", 32'(al_out), 32'd1);
    chk("al_press_cnt", al_press_cnt, 1);
    chk("al_rel_cnt0", al_rel_cnt, 0);
    key_al = 1'b1;
    repeat (FL * TD + TD + 8) @(negedge clk);
    chk("al_rel_out", 32'(al_out), 32'd0);
    chk("al_press_cnt1", al_press_cnt, 1);
    chk("al_rel_cnt1", al_rel_cnt, 1);
    chk("al_long_cnt", al_long_cnt, 0);

    repeat (20) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
